// File: rtl/toy_pkg.sv
// toy_pkg: shared state type, opcode slice and sizes for the TOY panel.
// Imported by the panel sequencer, its interface and edge detector.
package toy_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int OP_W   = OP_MSB - OP_LSB + 1;

   localparam logic [OP_W-1:0] HALT_OP = '0;

   localparam int NBTN   = 7;
   localparam int B_ADDR = 0;
   localparam int B_LOOK = 1;
   localparam int B_LOAD = 2;
   localparam int B_PC   = 3;
   localparam int B_STEP = 4;
   localparam int B_RUN  = 5;
   localparam int B_STOP = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MEM,
      ST_PCSET,
      ST_STEP_ISSUE,
      ST_STEP_WAIT,
      ST_RUN,
      ST_DRAIN
   } panel_state_t;

endpackage

// File: rtl/toy_panel_ctrl_if.sv
// toy_panel_ctrl_if: panel memory port (request/ack, one word per access).
// master = panel sequencer, slave = memory.
interface toy_panel_ctrl_if
   import toy_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              req;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, wen, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, wen, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/toy_panel_edge.sv
// toy_panel_edge: rising-edge detector per button bit.
// A button already high when reset releases never produces an edge.
module toy_panel_edge
   import toy_pkg::*;
#(
   parameter int N = NBTN
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] btn_i,
   output logic [N-1:0] rise_o
);

   logic [N-1:0] prev_q;
   logic         armed_q;

   // history of button levels; first cycle after reset only primes it
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         prev_q  <= btn_i;
         armed_q <= 1'b1;
      end
   end

   assign rise_o = btn_i & ~prev_q & {N{armed_q}};

endmodule

// File: rtl/toy_panel_ctrl.sv
// toy_panel_ctrl: TOY front-panel sequencer (PC set, step, run/stop, examine/deposit).
// Build option TOY_PANEL_AUTOINC_EN: address register steps after each look/load.
module toy_panel_ctrl
   import toy_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                btn_addr_i,
   input  logic                btn_look_i,
   input  logic                btn_load_i,
   input  logic                btn_pc_i,
   input  logic                btn_step_i,
   input  logic                btn_run_i,
   input  logic                btn_stop_i,
   input  logic [ADDR_W-1:0]   addr_sw_i,
   input  logic [DATA_W-1:0]   data_sw_i,
   output logic                cpu_exec_o,
   output logic                pc_wen_o,
   output logic [ADDR_W-1:0]   pc_o,
   input  logic [ADDR_W-1:0]   pc_i,
   input  logic                instr_val_i,
   input  logic [DATA_W-1:0]   instr_data_i,
   input  logic                cpu_running_i,
   toy_panel_ctrl_if.master    mem,
   output logic [ADDR_W-1:0]   disp_addr_o,
   output logic [DATA_W-1:0]   disp_data_o,
   output logic                run_led_o,
   output logic                busy_o
);

   panel_state_t      state;
   logic [ADDR_W-1:0] addr_q;
   logic              seen_q;
   logic [NBTN-1:0]   btn;
   logic [NBTN-1:0]   rise;
   logic [NBTN-1:0]   cmd;
   logic              halt;
   logic              trace;

   assign btn = {btn_stop_i, btn_run_i, btn_step_i, btn_pc_i,
                 btn_load_i, btn_look_i, btn_addr_i};

   toy_panel_edge #(.N(NBTN)) u_edge (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .btn_i  (btn),
      .rise_o (rise)
   );

   // keep only the highest-priority edge of this cycle
   always_comb begin
      cmd = '0;
      priority case (1'b1)
         rise[B_STOP]: cmd[B_STOP] = 1'b1;
         rise[B_RUN]:  cmd[B_RUN]  = 1'b1;
         rise[B_STEP]: cmd[B_STEP] = 1'b1;
         rise[B_PC]:   cmd[B_PC]   = 1'b1;
         rise[B_LOAD]: cmd[B_LOAD] = 1'b1;
         rise[B_LOOK]: cmd[B_LOOK] = 1'b1;
         rise[B_ADDR]: cmd[B_ADDR] = 1'b1;
         default:      cmd = '0;
      endcase
   end

   assign halt  = instr_val_i
                & (instr_data_i[OP_MSB:OP_LSB] == HALT_OP);
   assign trace = (state == ST_STEP_WAIT)
                | (state == ST_RUN)
                | (state == ST_DRAIN);

   assign busy_o    = (state != ST_IDLE);
   assign run_led_o = (state == ST_RUN) | (state == ST_DRAIN);

   // panel sequencer with registered core, memory and display outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         seen_q      <= 1'b0;
         cpu_exec_o  <= 1'b0;
         pc_wen_o    <= 1'b0;
         pc_o        <= '0;
         mem.req     <= 1'b0;
         mem.wen     <= 1'b0;
         mem.addr    <= '0;
         mem.wdata   <= '0;
         disp_addr_o <= '0;
         disp_data_o <= '0;
      end else begin
         pc_wen_o <= 1'b0;
         if (trace && instr_val_i) begin
            disp_addr_o <= pc_i;
            disp_data_o <= instr_data_i;
         end
         unique case (state)
            ST_IDLE: begin
               unique case (1'b1)
                  cmd[B_ADDR]: begin
                     addr_q      <= addr_sw_i;
                     disp_addr_o <= addr_sw_i;
                  end
                  cmd[B_LOOK]: begin
                     mem.req  <= 1'b1;
                     mem.wen  <= 1'b0;
                     mem.addr <= addr_q;
                     state    <= ST_MEM;
                  end
                  cmd[B_LOAD]: begin
                     mem.req   <= 1'b1;
                     mem.wen   <= 1'b1;
                     mem.addr  <= addr_q;
                     mem.wdata <= data_sw_i;
                     state     <= ST_MEM;
                  end
                  cmd[B_PC]: begin
                     pc_wen_o    <= 1'b1;
                     pc_o        <= addr_q;
                     disp_addr_o <= addr_q;
                     state       <= ST_PCSET;
                  end
                  cmd[B_STEP]: begin
                     cpu_exec_o <= 1'b1;
                     state      <= ST_STEP_ISSUE;
                  end
                  cmd[B_RUN]: begin
                     cpu_exec_o <= 1'b1;
                     state      <= ST_RUN;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               if (mem.ack) begin
                  mem.req     <= 1'b0;
                  disp_addr_o <= mem.addr;
                  disp_data_o <= mem.wen ? mem.wdata
                                         : mem.rdata;
`ifdef TOY_PANEL_AUTOINC_EN
                  addr_q      <= addr_q + ADDR_W'(1);
`endif
                  state       <= ST_IDLE;
               end
            end
            ST_PCSET: begin
               state <= ST_IDLE;
            end
            ST_STEP_ISSUE: begin
               cpu_exec_o <= 1'b0;
               seen_q     <= 1'b0;
               state      <= ST_STEP_WAIT;
            end
            ST_STEP_WAIT: begin
               if (cpu_running_i) begin
                  seen_q <= 1'b1;
               end
               if (seen_q && !cpu_running_i) begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (cmd[B_STOP] || halt) begin
                  cpu_exec_o <= 1'b0;
                  state      <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!cpu_running_i) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_toy_panel_ctrl.sv
// tb_toy_panel_ctrl: directed bench for the TOY panel sequencer.
// Expected display/memory values come from a small panel model kept here.
module tb_toy_panel_ctrl;

   localparam int AW = 8;
   localparam int DW = 16;

   localparam logic [6:0] M_ADDR = 7'b0000001;
   localparam logic [6:0] M_LOOK = 7'b0000010;
   localparam logic [6:0] M_LOAD = 7'b0000100;
   localparam logic [6:0] M_PC   = 7'b0001000;
   localparam logic [6:0] M_STEP = 7'b0010000;
   localparam logic [6:0] M_RUN  = 7'b0100000;
   localparam logic [6:0] M_STOP = 7'b1000000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [6:0]    btn = '0;
   logic [AW-1:0] addr_sw = '0;
   logic [DW-1:0] data_sw = '0;
   logic          cpu_exec;
   logic          pc_wen;
   logic [AW-1:0] pc_out;
   logic [AW-1:0] pc_core = '0;
   logic          instr_val = 1'b0;
   logic [DW-1:0] instr_data = '0;
   logic          running = 1'b0;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic          run_led;
   logic          busy;

   toy_panel_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

   always #5 clk = ~clk;

   toy_panel_ctrl dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .btn_addr_i    (btn[0]),
      .btn_look_i    (btn[1]),
      .btn_load_i    (btn[2]),
      .btn_pc_i      (btn[3]),
      .btn_step_i    (btn[4]),
      .btn_run_i     (btn[5]),
      .btn_stop_i    (btn[6]),
      .addr_sw_i     (addr_sw),
      .data_sw_i     (data_sw),
      .cpu_exec_o    (cpu_exec),
      .pc_wen_o      (pc_wen),
      .pc_o          (pc_out),
      .pc_i          (pc_core),
      .instr_val_i   (instr_val),
      .instr_data_i  (instr_data),
      .cpu_running_i (running),
      .mem           (mem),
      .disp_addr_o   (disp_addr),
      .disp_data_o   (disp_data),
      .run_led_o     (run_led),
      .busy_o        (busy)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // panel model
   logic [AW-1:0] m_addr = '0;
   logic [AW-1:0] m_disp_a = '0;
   logic [DW-1:0] m_disp_d = '0;
   logic [DW-1:0] m_mem [256];
   logic          chk_en = 1'b0;

   // memory slave
   logic [DW-1:0] ram [256];
   int mem_lat = 0;
   int lat_cnt = 0;

   initial begin
      mem.ack   = 1'b0;
      mem.rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem.ack = 1'b0;
         if (rst_n && mem.req) begin
            if (lat_cnt >= mem_lat) begin
               mem.ack = 1'b1;
               lat_cnt = 0;
               if (mem.wen) ram[mem.addr] = mem.wdata;
               else mem.rdata = ram[mem.addr];
            end else begin
               lat_cnt++;
            end
         end else begin
            lat_cnt = 0;
         end
      end
   end

   // per-cycle monitor and compare process
   int exec_cyc = 0;
   int pcw_cyc = 0;
   int req_cnt = 0;
   logic [AW-1:0] pcw_val = '0;
   logic          req_prev = 1'b0;
   logic          hold = 1'b0;
   logic [AW-1:0] h_addr = '0;
   logic          h_wen = 1'b0;
   logic [DW-1:0] h_wdata = '0;

   always @(negedge clk) begin
      if (cpu_exec) exec_cyc++;
      if (pc_wen) begin
         pcw_cyc++;
         pcw_val = pc_out;
      end
      if (mem.req && !req_prev) req_cnt++;
      if (mem.req && hold) begin
         chk("req_addr_stable", mem.addr, h_addr);
         chk("req_wen_stable", mem.wen, h_wen);
         chk("req_wdata_stable", mem.wdata, h_wdata);
      end
      if (mem.req) chk("req_while_core_idle", running, 0);
      hold = mem.req && !mem.ack;
      h_addr = mem.addr;
      h_wen = mem.wen;
      h_wdata = mem.wdata;
      req_prev = mem.req;
      if (chk_en) begin
         chk("disp_addr", disp_addr, m_disp_a);
         chk("disp_data", disp_data, m_disp_d);
         chk("idle_busy", busy, 0);
         chk("idle_exec", cpu_exec, 0);
      end
   end

   task automatic press(input logic [6:0] m);
      @(posedge clk); #1;
      btn = m;
      @(posedge clk); #1;
      btn = '0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_idle_timeout"}, busy, 0);
   endtask

   task automatic do_addr(input logic [AW-1:0] a);
      chk_en = 1'b0;
      addr_sw = a;
      press(M_ADDR);
      @(negedge clk);
      m_addr = a;
      m_disp_a = a;
      chk_en = 1'b1;
   endtask

   task automatic do_mem(input bit wr, input logic [DW-1:0] d);
      int r0;
      r0 = req_cnt;
      chk_en = 1'b0;
      data_sw = d;
      press(wr ? M_LOAD : M_LOOK);
      wait_idle(wr ? "load" : "look");
      if (wr) m_mem[m_addr] = d;
      m_disp_a = m_addr;
      m_disp_d = m_mem[m_addr];
      chk("mem_ram", ram[m_addr], m_mem[m_addr]);
      chk("mem_one_req", req_cnt - r0, 1);
`ifdef TOY_PANEL_AUTOINC_EN
      m_addr = m_addr + 8'd1;
`endif
      chk_en = 1'b1;
   endtask

   int r0;

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) begin
         m_mem[i] = {8'(i), ~8'(i)};
         ram[i] = {8'(i), ~8'(i)};
      end

      // reset with run held: outputs zero, no command afterwards
      btn = M_RUN;
      repeat (2) @(negedge clk);
      chk("rst_exec", cpu_exec, 0);
      chk("rst_pc_wen", pc_wen, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_req", mem.req, 0);
      chk("rst_wen", mem.wen, 0);
      chk("rst_maddr", mem.addr, 0);
      chk("rst_wdata", mem.wdata, 0);
      chk("rst_disp_a", disp_addr, 0);
      chk("rst_disp_d", disp_data, 0);
      chk("rst_led", run_led, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("held_btn_busy", busy, 0);
      chk("held_btn_exec_cyc", exec_cyc, 0);
      btn = '0;
      chk_en = 1'b1;

      // look at reset address 0
      do_mem(0, '0);
      chk("look0_data", disp_data, 16'h00FF);
      chk("look0_addr", disp_addr, 8'h00);

      // deposit then examine at 0x10, slow memory
      mem_lat = 2;
      do_addr(8'h10);
      do_mem(1, 16'hABCD);
      do_mem(0, '0);
      chk("dep_ram10", ram[8'h10], 16'hABCD);
`ifdef TOY_PANEL_AUTOINC_EN
      chk("ex_addr", disp_addr, 8'h11);
      chk("ex_data", disp_data, 16'h11EE);
`else
      chk("ex_addr", disp_addr, 8'h10);
      chk("ex_data", disp_data, 16'hABCD);
`endif
      mem_lat = 0;

      // two loads from 0xFF, then look
      do_addr(8'hFF);
      do_mem(1, 16'h1111);
      do_mem(1, 16'h2222);
      do_mem(0, '0);
`ifdef TOY_PANEL_AUTOINC_EN
      chk("wrap_ramff", ram[8'hFF], 16'h1111);
      chk("wrap_ram00", ram[8'h00], 16'h2222);
      chk("wrap_addr", disp_addr, 8'h01);
`else
      chk("wrap_ramff", ram[8'hFF], 16'h2222);
      chk("wrap_addr", disp_addr, 8'hFF);
      chk("wrap_data", disp_data, 16'h2222);
`endif

      // set PC
      do_addr(8'h10);
      r0 = pcw_cyc;
      chk_en = 1'b0;
      press(M_PC);
      wait_idle("pc");
      repeat (2) @(negedge clk);
      chk("pc_wen_cycles", pcw_cyc - r0, 1);
      chk("pc_value", pcw_val, 8'h10);
      m_disp_a = m_addr;
      chk("pc_disp", disp_addr, 8'h10);
      chk_en = 1'b1;

      // single step
      r0 = exec_cyc;
      chk_en = 1'b0;
      press(M_STEP);
      @(posedge clk); #1;
      running = 1'b1;
      @(posedge clk); #1;
      instr_val = 1'b1;
      pc_core = 8'h10;
      instr_data = 16'h1234;
      @(posedge clk); #1;
      instr_val = 1'b0;
      @(negedge clk);
      chk("step_busy", busy, 1);
      @(posedge clk); #1;
      running = 1'b0;
      wait_idle("step");
      chk("step_exec_cycles", exec_cyc - r0, 1);
      m_disp_a = 8'h10;
      m_disp_d = 16'h1234;
      chk("step_disp", disp_data, 16'h1234);
      chk_en = 1'b1;

      // run until halt word
      chk_en = 1'b0;
      press(M_RUN);
      chk("run_exec", cpu_exec, 1);
      chk("run_led", run_led, 1);
      @(posedge clk); #1;
      running = 1'b1;
      @(posedge clk); #1;
      instr_val = 1'b1;
      pc_core = 8'h21;
      instr_data = 16'h1ABC;
      @(posedge clk); #1;
      pc_core = 8'h22;
      instr_data = 16'h0000;
      @(negedge clk);
      chk("pre_halt_exec", cpu_exec, 1);
      @(posedge clk); #1;
      instr_val = 1'b0;
      chk("halt_exec", cpu_exec, 0);
      chk("drain_led", run_led, 1);
      chk("drain_busy", busy, 1);
      @(posedge clk); #1;
      running = 1'b0;
      wait_idle("halt");
      m_disp_a = 8'h22;
      m_disp_d = 16'h0000;
      chk("halt_pc_disp", disp_addr, 8'h22);
      chk_en = 1'b1;

      // stop and load together while running
      r0 = req_cnt;
      chk_en = 1'b0;
      data_sw = 16'hDEAD;
      press(M_RUN);
      @(posedge clk); #1;
      running = 1'b1;
      press(M_STOP | M_LOAD);
      chk("stop_exec", cpu_exec, 0);
      chk("stop_led", run_led, 1);
      @(posedge clk); #1;
      running = 1'b0;
      wait_idle("stop");
      repeat (3) @(negedge clk);
      chk("stop_no_req", req_cnt - r0, 0);
      chk("stop_ram", ram[m_addr], m_mem[m_addr]);
      chk_en = 1'b1;

      // reset while a request waits on slow memory
      chk_en = 1'b0;
      mem_lat = 40;
      r0 = req_cnt;
      press(M_LOOK);
      repeat (3) @(negedge clk);
      chk("mid_req", mem.req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req_drop", mem.req, 0);
      chk("async_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_lat = 0;
      repeat (4) @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_req_count", req_cnt - r0, 1);
      chk("post_rst_disp_a", disp_addr, 0);
      chk("post_rst_disp_d", disp_data, 0);
      m_addr = '0;
      m_disp_a = '0;
      m_disp_d = '0;
      chk_en = 1'b1;
      do_mem(0, '0);
      chk("post_rst_look_addr", disp_addr, 8'h00);

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected end");
      $fatal(1, "watchdog");
   end

endmodule
